// File: rtl/ncl_mult3_sched_pkg.sv
// Shared types and dual-rail helpers for the NCL_MULT3 scheduler.
package ncl_sched_pkg;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    DATA,
    NULL_PH,
    RESP,
    ERR
  } state_e;

  typedef struct packed {
    logic rail1;
    logic rail0;
  } dual_rail_t;

  function automatic dual_rail_t to_dual_rail(input logic b);
    return dual_rail_t'{rail1: b, rail0: ~b};
  endfunction

  function automatic logic is_null(input dual_rail_t d);
    return !(d.rail1 || d.rail0);
  endfunction

  function automatic logic is_data(input dual_rail_t d);
    return d.rail1 ^ d.rail0;
  endfunction

endpackage

// File: rtl/ncl_mult3_sched_if.sv
// Requester-side request/response bus of the NCL_MULT3 scheduler.
interface ncl_mult3_sched_if #(
  parameter int unsigned NREQ = 4
);
  localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]   req_valid;
  logic [NREQ*3-1:0] req_a;
  logic [NREQ*3-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [5:0]        rsp_prod;

  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, rsp_valid, rsp_id, rsp_prod
  );

  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, rsp_valid, rsp_id, rsp_prod
  );
endinterface

// File: rtl/ncl_mult3_sched_rr_arbiter.sv
// Round-robin arbiter: first asserted request at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]                                 req_i,
  input  logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0]      ptr_i,
  output logic [NREQ-1:0]                                 gnt_o,
  output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0]      idx_o,
  output logic                                            any_o
);
  localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  always_comb begin
    int unsigned j;
    j     = 0;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      j = (int'(ptr_i) + k) % NREQ;
      if (!any_o && req_i[IDW'(j)]) begin
        any_o            = 1'b1;
        gnt_o[IDW'(j)]   = 1'b1;
        idx_o            = IDW'(j);
      end
    end
  end
endmodule

// File: rtl/ncl_mult3_sched.sv
// Clocked scheduler sharing one asynchronous NCL_MULT3 among NREQ requesters.
// Optional illegal-rail detection enabled by NCL_SCHED_RAIL_CHECK_EN.
module ncl_mult3_sched
  import ncl_sched_pkg::*;
#(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  ncl_mult3_sched_if.slave     bus,
  output logic                 err_o,
`ifdef NCL_SCHED_RAIL_CHECK_EN
  output logic                 err_illegal_o,
`endif
  output logic [2:0]           mult_a_r1_o,
  output logic [2:0]           mult_a_r0_o,
  output logic [2:0]           mult_b_r1_o,
  output logic [2:0]           mult_b_r0_o,
  output logic                 mult_ki_o,
  output logic                 mult_rst_o,
  input  logic                 mult_ko_i,
  input  logic [5:0]           mult_p_r1_i,
  input  logic [5:0]           mult_p_r0_i
);
  localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW  = $clog2(TIMEOUT + 1);
  localparam int unsigned PW  = 6 * SYNC_STAGES;

  state_e                          state_q;
  logic [CW-1:0]                   cnt_q;
  logic [IDW-1:0]                  ptr_q, id_q;
  logic [2:0]                      a_r1_q, a_r0_q, b_r1_q, b_r0_q;
  logic                            ki_q, mult_rst_q;
  logic [NREQ-1:0]                 req_ready_q;
  logic                            rsp_valid_q;
  logic [IDW-1:0]                  rsp_id_q;
  logic [5:0]                      rsp_prod_q;
  logic                            err_q;

  logic [SYNC_STAGES-1:0]          ko_sync_q;
  logic [SYNC_STAGES-1:0][5:0]     p1_sync_q, p0_sync_q;
  logic                            ko_s;
  logic [5:0]                      p1_s, p0_s;
  logic                            all_data_c, all_null_c;
  logic                            data_done_q, null_done_q;
  logic                            init_done_c, wait_c, abort_c;

  logic [NREQ-1:0]                 gnt_c;
  logic [IDW-1:0]                  gidx_c;
  logic                            any_c;
  logic [2:0]                      a_sel_c, b_sel_c;

  // Async-input synchronizers plus registered completion detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      ko_sync_q   <= '0;
      p1_sync_q   <= '0;
      p0_sync_q   <= '0;
      data_done_q <= 1'b0;
      null_done_q <= 1'b0;
    end else begin
      ko_sync_q   <= SYNC_STAGES'({ko_sync_q, mult_ko_i});
      p1_sync_q   <= PW'({p1_sync_q, mult_p_r1_i});
      p0_sync_q   <= PW'({p0_sync_q, mult_p_r0_i});
      data_done_q <= !ko_s && all_data_c;
      null_done_q <= ko_s && all_null_c;
    end
  end

  assign ko_s = ko_sync_q[SYNC_STAGES-1];
  assign p1_s = p1_sync_q[SYNC_STAGES-1];
  assign p0_s = p0_sync_q[SYNC_STAGES-1];

  always_comb begin
    all_data_c = 1'b1;
    all_null_c = 1'b1;
    for (int i = 0; i < 6; i++) begin
      all_data_c = all_data_c & is_data(dual_rail_t'({p1_s[i], p0_s[i]}));
      all_null_c = all_null_c & is_null(dual_rail_t'({p1_s[i], p0_s[i]}));
    end
  end

`ifdef NCL_SCHED_RAIL_CHECK_EN
  // Both rails of any product bit high on two consecutive synced samples.
  logic illegal_d, illegal_q, illegal_hit_c, err_illegal_q;
  assign illegal_d     = |(p1_s & p0_s);
  assign illegal_hit_c = illegal_q && illegal_d;
  always_ff @(posedge clk) begin
    if (rst) illegal_q <= 1'b0;
    else     illegal_q <= illegal_d;
  end
`endif

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_i (bus.req_valid),
    .ptr_i (ptr_q),
    .gnt_o (gnt_c),
    .idx_o (gidx_c),
    .any_o (any_c)
  );

  assign a_sel_c = 3'(bus.req_a >> (3 * int'(gidx_c)));
  assign b_sel_c = 3'(bus.req_b >> (3 * int'(gidx_c)));

  assign init_done_c = !mult_rst_q && null_done_q;

  always_comb begin
    wait_c = 1'b0;
    case (state_q)
      INIT:    wait_c = !init_done_c;
      DATA:    wait_c = !data_done_q;
      NULL_PH: wait_c = !null_done_q;
      default: wait_c = 1'b0;
    endcase
    abort_c = wait_c && (cnt_q == CW'(TIMEOUT - 1));
`ifdef NCL_SCHED_RAIL_CHECK_EN
    abort_c = abort_c || illegal_hit_c;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      ptr_q       <= '0;
      id_q        <= '0;
      a_r1_q      <= '0;
      a_r0_q      <= '0;
      b_r1_q      <= '0;
      b_r0_q      <= '0;
      ki_q        <= 1'b0;
      mult_rst_q  <= 1'b1;
      req_ready_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_prod_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      req_ready_q <= '0;
      rsp_valid_q <= 1'b0;
      if (abort_c) begin
        state_q    <= ERR;
        err_q      <= 1'b1;
        a_r1_q     <= '0;
        a_r0_q     <= '0;
        b_r1_q     <= '0;
        b_r0_q     <= '0;
        ki_q       <= 1'b0;
        mult_rst_q <= 1'b1;
      end else begin
        case (state_q)
          INIT: begin
            if (cnt_q >= CW'(SYNC_STAGES)) mult_rst_q <= 1'b0;
            if (init_done_c) state_q <= IDLE;
            else             cnt_q   <= cnt_q + 1'b1;
          end
          IDLE: begin
            if (any_c) begin
              req_ready_q <= gnt_c;
              id_q        <= gidx_c;
              ptr_q       <= (gidx_c == IDW'(NREQ - 1)) ? '0 : gidx_c + 1'b1;
              for (int i = 0; i < 3; i++) begin
                {a_r1_q[i], a_r0_q[i]} <= to_dual_rail(a_sel_c[i]);
                {b_r1_q[i], b_r0_q[i]} <= to_dual_rail(b_sel_c[i]);
              end
              ki_q    <= 1'b1;
              cnt_q   <= '0;
              state_q <= DATA;
            end
          end
          DATA: begin
            if (data_done_q) begin
              rsp_prod_q <= p1_s;
              rsp_id_q   <= id_q;
              a_r1_q     <= '0;
              a_r0_q     <= '0;
              b_r1_q     <= '0;
              b_r0_q     <= '0;
              ki_q       <= 1'b0;
              cnt_q      <= '0;
              state_q    <= NULL_PH;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          NULL_PH: begin
            if (null_done_q) begin
              rsp_valid_q <= 1'b1;
              state_q     <= RESP;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          RESP:    state_q <= IDLE;
          ERR:     state_q <= ERR;
          default: state_q <= ERR;
        endcase
      end
    end
  end

`ifdef NCL_SCHED_RAIL_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst)                err_illegal_q <= 1'b0;
    else if (illegal_hit_c) err_illegal_q <= 1'b1;
  end
  assign err_illegal_o = err_illegal_q;
`endif

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_prod  = rsp_prod_q;
  assign err_o         = err_q;
  assign mult_a_r1_o   = a_r1_q;
  assign mult_a_r0_o   = a_r0_q;
  assign mult_b_r1_o   = b_r1_q;
  assign mult_b_r0_o   = b_r0_q;
  assign mult_ki_o     = ki_q;
  assign mult_rst_o    = mult_rst_q;
endmodule

// File: tb/tb_ncl_mult3_sched.sv
// Directed bench for ncl_mult3_sched with a behavioural NCL_MULT3 model.
module tb_ncl_mult3_sched;
  import ncl_sched_pkg::*;

  localparam int NREQ    = 4;
  localparam int SYNC    = 2;
  localparam int TMO     = 255;

  logic clk = 1'b0;
  logic rst;
  logic err;
`ifdef NCL_SCHED_RAIL_CHECK_EN
  logic err_illegal;
`endif
  logic [2:0] a_r1, a_r0, b_r1, b_r0;
  logic       mult_ki, mult_rst;
  logic       m_ko;
  logic [5:0] m_p1, m_p0;
  bit         stall;

  int n_vec = 0;
  int n_err = 0;

  ncl_mult3_sched_if #(.NREQ(NREQ)) bus ();

  ncl_mult3_sched #(.NREQ(NREQ), .SYNC_STAGES(SYNC), .TIMEOUT(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .err_o       (err),
`ifdef NCL_SCHED_RAIL_CHECK_EN
    .err_illegal_o (err_illegal),
`endif
    .mult_a_r1_o (a_r1),
    .mult_a_r0_o (a_r0),
    .mult_b_r1_o (b_r1),
    .mult_b_r0_o (b_r0),
    .mult_ki_o   (mult_ki),
    .mult_rst_o  (mult_rst),
    .mult_ko_i   (m_ko),
    .mult_p_r1_i (m_p1),
    .mult_p_r0_i (m_p0)
  );

  always #5 clk = ~clk;

  // NCL_MULT3 model: reacts half a cycle after rails change; hysteresis holds state.
  wire       ops_data = (&(a_r1 ^ a_r0)) && (&(b_r1 ^ b_r0));
  wire       ops_null = ({a_r1, a_r0, b_r1, b_r0} == 12'd0);
  wire [5:0] m_prod   = 6'(a_r1) * 6'(b_r1);

  always @(negedge clk) begin
    if (mult_rst !== 1'b0) begin
      m_ko <= 1'b1; m_p1 <= '0; m_p0 <= '0;
    end else if (mult_ki && ops_data && !stall) begin
      m_ko <= 1'b0; m_p1 <= m_prod; m_p0 <= ~m_prod;
    end else if (!mult_ki && ops_null) begin
      m_ko <= 1'b1; m_p1 <= '0; m_p0 <= '0;
    end
  end

  // Records whether a complete NULL wavefront preceded each DATA wavefront.
  bit null_seen, null_ok_at_rise, ki_prev;
  always @(negedge clk) begin
    if (mult_ki === 1'b1 && !ki_prev) begin
      null_ok_at_rise <= null_seen;
      null_seen       <= 1'b0;
    end else if (ops_null && mult_ki === 1'b0 && m_ko === 1'b1 && m_p1 == 6'd0 && m_p0 == 6'd0) begin
      null_seen <= 1'b1;
    end
    ki_prev <= (mult_ki === 1'b1);
  end

  typedef struct {
    bit         ok;
    logic [3:0] gnt;
    logic [2:0] ar1, ar0, br1, br0;
    logic       ki;
    logic [1:0] id;
    logic [5:0] prod;
    int         lat;
    bit         one_cycle;
  } op_res_t;

  task automatic do_op(input int id, input logic [2:0] a, input logic [2:0] b, output op_res_t r);
    logic [11:0] av, bv;
    logic [3:0]  rv;
    bit          got;
    r   = '{default: '0};
    av  = bus.req_a; av[3*id +: 3] = a; bus.req_a = av;
    bv  = bus.req_b; bv[3*id +: 3] = b; bus.req_b = bv;
    rv  = bus.req_valid; rv[id] = 1'b1; bus.req_valid = rv;
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      if (bus.req_ready != 4'd0) got = 1'b1;
    end
    rv[id] = 1'b0; bus.req_valid = rv;
    if (!got) return;
    r.gnt = bus.req_ready;
    r.ar1 = a_r1; r.ar0 = a_r0; r.br1 = b_r1; r.br0 = b_r0; r.ki = mult_ki;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) begin
        r.ok = 1'b1; r.lat = c; r.id = bus.rsp_id; r.prod = bus.rsp_prod;
        break;
      end
    end
    if (r.ok) begin
      @(negedge clk);
      r.one_cycle = (bus.rsp_valid === 1'b0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0;
    bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({a_r1, a_r0, b_r1, b_r0, mult_ki} !== 13'd0) begin
      n_err++; $display("FAIL reset_rails got=%h want=0", {a_r1, a_r0, b_r1, b_r0, mult_ki});
    end
    n_vec++;
    if (mult_rst !== 1'b1) begin n_err++; $display("FAIL reset_mult_rst got=%b want=1", mult_rst); end
    n_vec++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_prod, err} !== 14'd0) begin
      n_err++; $display("FAIL reset_outputs got=%h want=0", {bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_prod, err});
    end
    rst = 1'b0;
    repeat (SYNC) @(negedge clk);
    n_vec++;
    if (mult_rst !== 1'b1) begin n_err++; $display("FAIL init_rst_hold got=%b want=1", mult_rst); end
    @(negedge clk);
    n_vec++;
    if (mult_rst !== 1'b0) begin n_err++; $display("FAIL init_rst_release got=%b want=0", mult_rst); end
    repeat (3) @(negedge clk);
    n_vec++;
    if (dut.state_q !== IDLE) begin n_err++; $display("FAIL init_exit got=%0d want=%0d", dut.state_q, IDLE); end
    n_vec++;
    if ({a_r1, a_r0, b_r1, b_r0, mult_ki} !== 13'd0) begin
      n_err++; $display("FAIL init_rails got=%h want=0", {a_r1, a_r0, b_r1, b_r0, mult_ki});
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] gnts [5];
    logic [1:0] ids  [5];
    logic [5:0] prods[5];
    int ng, nr;
    ng = 0; nr = 0;
    bus.req_a = 12'hFFF; bus.req_b = 12'hFFF; bus.req_valid = 4'hF;
    for (int c = 0; c < 200 && nr < 5; c++) begin
      @(negedge clk);
      if (bus.req_ready != 4'd0 && ng < 5) begin gnts[ng] = bus.req_ready; ng++; end
      if (bus.rsp_valid === 1'b1) begin
        ids[nr] = bus.rsp_id; prods[nr] = bus.rsp_prod; nr++;
        if (nr == 5) bus.req_valid = 4'h0;
      end
    end
    bus.req_valid = 4'h0;
    n_vec++;
    if (nr != 5) begin n_err++; $display("FAIL rr_rsp_count got=%0d want=5", nr); end
    for (int k = 0; k < nr; k++) begin
      n_vec++;
      if (gnts[k] !== 4'(1 << (k % 4))) begin
        n_err++; $display("FAIL rr_grant%0d got=%b want=%b", k, gnts[k], 4'(1 << (k % 4)));
      end
      n_vec++;
      if (ids[k] !== 2'(k % 4)) begin n_err++; $display("FAIL rr_id%0d got=%0d want=%0d", k, ids[k], k % 4); end
      n_vec++;
      if (prods[k] !== 6'd49) begin n_err++; $display("FAIL rr_prod%0d got=%0d want=49", k, prods[k]); end
    end
  endtask

  task automatic test_single();
    op_res_t r;
    do_op(2, 3'd5, 3'd7, r);
    n_vec++;
    if (!r.ok) begin n_err++; $display("FAIL single_complete got=0 want=1"); end
    n_vec++;
    if (r.gnt !== 4'b0100) begin n_err++; $display("FAIL single_grant got=%b want=0100", r.gnt); end
    n_vec++;
    if ({r.ar1, r.ar0} !== {3'b101, 3'b010}) begin
      n_err++; $display("FAIL single_a_rails got=%b_%b want=101_010", r.ar1, r.ar0);
    end
    n_vec++;
    if ({r.br1, r.br0, r.ki} !== {3'b111, 3'b000, 1'b1}) begin
      n_err++; $display("FAIL single_b_rails_ki got=%b_%b_%b want=111_000_1", r.br1, r.br0, r.ki);
    end
    n_vec++;
    if (r.id !== 2'd2) begin n_err++; $display("FAIL single_id got=%0d want=2", r.id); end
    n_vec++;
    if (r.prod !== 6'd35) begin n_err++; $display("FAIL single_prod got=%0d want=35", r.prod); end
    n_vec++;
    if (r.lat != 2 * SYNC + 4) begin n_err++; $display("FAIL single_latency got=%0d want=%0d", r.lat, 2 * SYNC + 4); end
    n_vec++;
    if (!r.one_cycle) begin n_err++; $display("FAIL single_rsp_pulse got=2+cycles want=1"); end
  endtask

  task automatic test_zero_then_seven();
    op_res_t r0, r1;
    do_op(0, 3'd0, 3'd0, r0);
    do_op(1, 3'd7, 3'd1, r1);
    n_vec++;
    if (!(r0.ok && r1.ok)) begin n_err++; $display("FAIL zs_complete got=%b%b want=11", r0.ok, r1.ok); end
    n_vec++;
    if (r0.prod !== 6'd0) begin n_err++; $display("FAIL zs_prod0 got=%0d want=0", r0.prod); end
    n_vec++;
    if (r1.prod !== 6'd7) begin n_err++; $display("FAIL zs_prod7 got=%0d want=7", r1.prod); end
    n_vec++;
    if (null_ok_at_rise !== 1'b1) begin n_err++; $display("FAIL zs_null_between got=%b want=1", null_ok_at_rise); end
  endtask

  task automatic test_timeout();
    bit got;
    int cyc, rsps;
    stall = 1'b1;
    bus.req_a = 12'h003; bus.req_b = 12'h003; bus.req_valid = 4'b0001;
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      if (bus.req_ready != 4'd0) got = 1'b1;
    end
    bus.req_valid = 4'b0000;
    cyc = 0; rsps = 0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) rsps++;
      if (err === 1'b1) begin cyc = c; break; end
    end
    n_vec++;
    if (!got) begin n_err++; $display("FAIL tmo_grant got=0 want=1"); end
    n_vec++;
    if (cyc != TMO) begin n_err++; $display("FAIL tmo_cycles got=%0d want=%0d", cyc, TMO); end
    n_vec++;
    if ({a_r1, a_r0, b_r1, b_r0, mult_ki, mult_rst} !== 14'b1) begin
      n_err++; $display("FAIL tmo_err_outputs got=%b want=%b", {a_r1, a_r0, b_r1, b_r0, mult_ki, mult_rst}, 14'b1);
    end
    repeat (5) @(negedge clk) if (bus.rsp_valid === 1'b1) rsps++;
    n_vec++;
    if (err !== 1'b1) begin n_err++; $display("FAIL tmo_sticky got=%b want=1", err); end
    n_vec++;
    if (rsps != 0) begin n_err++; $display("FAIL tmo_no_rsp got=%0d want=0", rsps); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if (err !== 1'b0) begin n_err++; $display("FAIL tmo_rst_clears got=%b want=0", err); end
    stall = 1'b0; rst = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_rst_mid_data();
    op_res_t r;
    bit got;
    int rsps;
    stall = 1'b1;
    bus.req_a = 12'h200; bus.req_b = 12'h300; bus.req_valid = 4'b1000;
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      if (bus.req_ready != 4'd0) got = 1'b1;
    end
    bus.req_valid = 4'b0000;
    repeat (2) @(negedge clk);
    n_vec++;
    if (!got || mult_ki !== 1'b1) begin n_err++; $display("FAIL rstmid_in_data got=%b%b want=11", got, mult_ki); end
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({a_r1, a_r0, b_r1, b_r0, mult_ki, mult_rst} !== 14'b1) begin
      n_err++; $display("FAIL rstmid_null got=%b want=%b", {a_r1, a_r0, b_r1, b_r0, mult_ki, mult_rst}, 14'b1);
    end
    stall = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    rsps = 0;
    repeat (12) @(negedge clk) if (bus.rsp_valid === 1'b1) rsps++;
    n_vec++;
    if (rsps != 0) begin n_err++; $display("FAIL rstmid_no_rsp got=%0d want=0", rsps); end
    do_op(1, 3'd6, 3'd5, r);
    n_vec++;
    if (!r.ok || r.gnt !== 4'b0010) begin n_err++; $display("FAIL rstmid_recover_grant got=%b/%b want=1/0010", r.ok, r.gnt); end
    n_vec++;
    if ({r.id, r.prod} !== {2'd1, 6'd30}) begin
      n_err++; $display("FAIL rstmid_recover_rsp got=%0d/%0d want=1/30", r.id, r.prod);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_zero_then_seven();
    test_timeout();
    test_rst_mid_data();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog expired");
  end
endmodule
